// File: rtl/wb_arbiter_pkg.sv
// Shared writeback constants: opcodes, fixed register indices, multdiv status codes.
// Also the multdiv buffer record and the arbiter state encoding.
package wb_arbiter_pkg;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_SETX = 5'b10101;

    localparam logic [4:0]  REG_STATUS  = 5'd30;
    localparam logic [4:0]  REG_RA      = 5'd31;
    localparam logic [31:0] STATUS_MULT = 32'd4;
    localparam logic [31:0] STATUS_DIV  = 32'd5;

    typedef enum logic [1:0] {SEL_O, SEL_D, SEL_T} wb_sel_e;
    typedef enum logic {MD_EMPTY, MD_FULL} md_state_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] result;
        logic        is_div;
        logic        exception;
    } md_buf_t;

    function automatic logic [31:0] md_status(input logic is_div);
        return is_div ? STATUS_DIV : STATUS_MULT;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bundle: pipeline MEM/WB entry, multdiv result handshake, register-file write port.
interface wb_arbiter_if;
    logic        mw_valid;
    logic [31:0] mw_ir;
    logic [31:0] mw_o;
    logic [31:0] mw_d;
    logic        mw_ready;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_result;
    logic        md_is_div;
    logic        md_exception;
    logic        md_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    modport slave (
        input  mw_valid, mw_ir, mw_o, mw_d,
        output mw_ready,
        input  md_valid, md_rd, md_result, md_is_div, md_exception,
        output md_ready,
        output rf_we, rf_waddr, rf_wdata
    );

    modport master (
        output mw_valid, mw_ir, mw_o, mw_d,
        input  mw_ready,
        output md_valid, md_rd, md_result, md_is_div, md_exception,
        input  md_ready,
        input  rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/wb_decode.sv
// Combinational writeback decode of the opcode/rd fields; zero latency, no backpressure.
// Writes to r0 are folded into o_we here so the arbiter never sees them.
module wb_decode
    import wb_arbiter_pkg::*;
(
    input  logic [31:22] i_ir,
    output logic         o_we,
    output logic [4:0]   o_waddr,
    output wb_sel_e      o_sel
);

    logic       w_we;
    logic [4:0] w_waddr;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = i_ir[26:22];
        o_sel   = SEL_O;
        case (i_ir[31:27])
            OP_ALU, OP_ADDI: w_we = 1'b1;
            OP_LW: begin
                w_we  = 1'b1;
                o_sel = SEL_D;
            end
            OP_JAL: begin
                w_we    = 1'b1;
                w_waddr = REG_RA;
            end
            OP_SETX: begin
                w_we    = 1'b1;
                w_waddr = REG_STATUS;
                o_sel   = SEL_T;
            end
            OP_SW:   ;
            default: ;
        endcase
    end

    assign o_we    = w_we && (w_waddr != 5'd0);
    assign o_waddr = w_waddr;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipeline entries write rf one edge after acceptance; a buffered multdiv
// result drains on the next edge and stalls the pipeline (mw_ready=0) for that one cycle.
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          clr,
    wb_arbiter_if.slave   bus
);

    md_state_e   r_state;
    md_buf_t     r_buf;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_rf_wdata;

    logic        w_dec_we;
    logic [4:0]  w_dec_waddr;
    wb_sel_e     w_dec_sel;
    logic [31:0] w_mw_data;
    logic        w_drain_we;
    logic [4:0]  w_drain_waddr;
    logic [31:0] w_drain_wdata;

    wb_decode u_decode (
        .i_ir    (bus.mw_ir[31:22]),
        .o_we    (w_dec_we),
        .o_waddr (w_dec_waddr),
        .o_sel   (w_dec_sel)
    );

    always_comb begin
        w_mw_data = bus.mw_o;
        case (w_dec_sel)
            SEL_D:   w_mw_data = bus.mw_d;
            SEL_T:   w_mw_data = {5'd0, bus.mw_ir[26:0]};
            default: w_mw_data = bus.mw_o;
        endcase
    end

    // Exceptions report through the status register regardless of the captured rd/result.
    assign w_drain_waddr = r_buf.exception ? REG_STATUS : r_buf.rd;
    assign w_drain_wdata = r_buf.exception ? md_status(r_buf.is_div) : r_buf.result;
    assign w_drain_we    = (w_drain_waddr != 5'd0);

    assign bus.mw_ready = (r_state == MD_EMPTY);
    assign bus.md_ready = (r_state == MD_EMPTY);
    assign bus.rf_we    = r_rf_we;
    assign bus.rf_waddr = r_rf_waddr;
    assign bus.rf_wdata = r_rf_wdata;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= MD_EMPTY;
            r_buf      <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_rf_wdata <= 32'd0;
        end else begin
            r_rf_we <= 1'b0;
            case (r_state)
                MD_EMPTY: begin
                    if (bus.mw_valid) begin
                        r_rf_we <= w_dec_we;
                        if (w_dec_we) begin
                            r_rf_waddr <= w_dec_waddr;
                            r_rf_wdata <= w_mw_data;
                        end
                    end
                    if (bus.md_valid) begin
                        r_buf.rd        <= bus.md_rd;
                        r_buf.result    <= bus.md_result;
                        r_buf.is_div    <= bus.md_is_div;
                        r_buf.exception <= bus.md_exception;
                        r_state         <= MD_FULL;
                    end
                end
                MD_FULL: begin
                    r_rf_we <= w_drain_we;
                    if (w_drain_we) begin
                        r_rf_waddr <= w_drain_waddr;
                        r_rf_wdata <= w_drain_wdata;
                    end
                    r_state <= MD_EMPTY;
                end
                default: r_state <= MD_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: decode vector table plus hand-written multdiv/reset sequences.
module tb_wb_arbiter;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    wb_arbiter_if bus ();

    wb_arbiter u_dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    typedef struct {
        logic        v;
        logic [31:0] ir;
        logic [31:0] o;
        logic [31:0] d;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd);
        return {op, rd, 22'h2A5A5};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string name, input logic we, input logic [4:0] waddr,
                            input logic [31:0] wdata);
        check({name, ".we"}, {31'd0, bus.rf_we}, {31'd0, we});
        if (we) begin
            check({name, ".waddr"}, {27'd0, bus.rf_waddr}, {27'd0, waddr});
            check({name, ".wdata"}, bus.rf_wdata, wdata);
        end
    endtask

    task automatic md_drive(input logic v, input logic [4:0] rd, input logic [31:0] res,
                            input logic is_div, input logic exc);
        bus.md_valid     = v;
        bus.md_rd        = rd;
        bus.md_result    = res;
        bus.md_is_div    = is_div;
        bus.md_exception = exc;
    endtask

    initial begin
        bus.mw_valid = 1'b0;
        bus.mw_ir    = 32'd0;
        bus.mw_o     = 32'd0;
        bus.mw_d     = 32'd0;
        md_drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

        vecs[0] = '{1'b1, mk(5'b00101, 5'd5),  32'h1234,     32'h0,        1'b1, 5'd5,  32'h00001234};
        vecs[1] = '{1'b1, mk(5'b01000, 5'd7),  32'h10,       32'hDEADBEEF, 1'b1, 5'd7,  32'hDEADBEEF};
        vecs[2] = '{1'b1, mk(5'b00111, 5'd7),  32'h20,       32'h1,        1'b0, 5'd0,  32'h0};
        vecs[3] = '{1'b1, mk(5'b00010, 5'd4),  32'h30,       32'h2,        1'b0, 5'd0,  32'h0};
        vecs[4] = '{1'b1, mk(5'b00011, 5'd2),  32'h00000055, 32'h3,        1'b1, 5'd31, 32'h00000055};
        vecs[5] = '{1'b1, {5'b10101, 27'h0000123}, 32'h77,   32'h4,        1'b1, 5'd30, 32'h00000123};
        vecs[6] = '{1'b1, mk(5'b00101, 5'd0),  32'h999,      32'h5,        1'b0, 5'd0,  32'h0};
        vecs[7] = '{1'b1, mk(5'b00000, 5'd12), 32'hCAFEF00D, 32'h6,        1'b1, 5'd12, 32'hCAFEF00D};
        vecs[8] = '{1'b0, mk(5'b00101, 5'd4),  32'h4444,     32'h7,        1'b0, 5'd0,  32'h0};
        vecs[9] = '{1'b1, mk(5'b01000, 5'd31), 32'h8,        32'h00000001, 1'b1, 5'd31, 32'h00000001};

        // Reset values, held across a clock edge.
        tick();
        tick();
        check("rst.we",       {31'd0, bus.rf_we},    32'd0);
        check("rst.waddr",    {27'd0, bus.rf_waddr}, 32'd0);
        check("rst.wdata",    bus.rf_wdata,          32'd0);
        check("rst.mw_ready", {31'd0, bus.mw_ready}, 32'd1);
        check("rst.md_ready", {31'd0, bus.md_ready}, 32'd1);
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("post_rst.mw_ready", {31'd0, bus.mw_ready}, 32'd1);
        check("post_rst.md_ready", {31'd0, bus.md_ready}, 32'd1);
        tick();
        check("post_rst.we", {31'd0, bus.rf_we}, 32'd0);

        // Pipeline decode table.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.mw_valid = vecs[i].v;
            bus.mw_ir    = vecs[i].ir;
            bus.mw_o     = vecs[i].o;
            bus.mw_d     = vecs[i].d;
            #1;
            check($sformatf("vec%0d.mw_ready", i), {31'd0, bus.mw_ready}, 32'd1);
            tick();
            check_wr($sformatf("vec%0d", i), vecs[i].we, vecs[i].waddr, vecs[i].wdata);
        end
        @(negedge clk);
        bus.mw_valid = 1'b0;
        tick();
        check("idle.we", {31'd0, bus.rf_we}, 32'd0);

        // Simultaneous pipeline entry and multdiv result; held pipeline entry waits out the drain.
        @(negedge clk);
        bus.mw_valid = 1'b1;
        bus.mw_ir    = mk(5'b00101, 5'd3);
        bus.mw_o     = 32'd7;
        md_drive(1'b1, 5'd9, 32'd42, 1'b0, 1'b0);
        tick();
        check_wr("both.e1", 1'b1, 5'd3, 32'd7);
        check("both.e1.mw_ready", {31'd0, bus.mw_ready}, 32'd0);
        check("both.e1.md_ready", {31'd0, bus.md_ready}, 32'd0);
        @(negedge clk);
        md_drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        bus.mw_ir = mk(5'b00101, 5'd6);
        bus.mw_o  = 32'h66;
        tick();
        check_wr("both.e2", 1'b1, 5'd9, 32'd42);
        check("both.e2.mw_ready", {31'd0, bus.mw_ready}, 32'd1);
        tick();
        check_wr("both.e3", 1'b1, 5'd6, 32'h66);
        @(negedge clk);
        bus.mw_valid = 1'b0;
        tick();
        check("both.e4.we", {31'd0, bus.rf_we}, 32'd0);

        // Div exception with md_valid held through FULL; the held request must not re-capture.
        @(negedge clk);
        md_drive(1'b1, 5'd9, 32'd99, 1'b1, 1'b1);
        tick();
        check("divx.e1.we",       {31'd0, bus.rf_we},    32'd0);
        check("divx.e1.md_ready", {31'd0, bus.md_ready}, 32'd0);
        tick();
        check_wr("divx.e2", 1'b1, 5'd30, 32'd5);
        check("divx.e2.md_ready", {31'd0, bus.md_ready}, 32'd1);
        @(negedge clk);
        md_drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        check("divx.e3.we", {31'd0, bus.rf_we}, 32'd0);
        tick();
        check("divx.e4.we", {31'd0, bus.rf_we}, 32'd0);

        // Mult exception.
        @(negedge clk);
        md_drive(1'b1, 5'd11, 32'd123, 1'b0, 1'b1);
        tick();
        @(negedge clk);
        md_drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        check_wr("mulx", 1'b1, 5'd30, 32'd4);

        // Multdiv result targeting r0 is consumed without a write.
        @(negedge clk);
        md_drive(1'b1, 5'd0, 32'd77, 1'b0, 1'b0);
        tick();
        check("md_r0.md_ready", {31'd0, bus.md_ready}, 32'd0);
        @(negedge clk);
        md_drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tick();
        check("md_r0.we",       {31'd0, bus.rf_we},    32'd0);
        check("md_r0.md_ready", {31'd0, bus.md_ready}, 32'd1);

        // Reset while FULL with a write on the port: everything dropped at once.
        @(negedge clk);
        bus.mw_valid = 1'b1;
        bus.mw_ir    = mk(5'b00101, 5'd5);
        bus.mw_o     = 32'h11;
        md_drive(1'b1, 5'd12, 32'hAA, 1'b0, 1'b0);
        tick();
        check_wr("clr.pre", 1'b1, 5'd5, 32'h11);
        @(negedge clk);
        bus.mw_valid = 1'b0;
        md_drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        clr = 1'b1;
        #1;
        check("clr.we",       {31'd0, bus.rf_we},    32'd0);
        check("clr.waddr",    {27'd0, bus.rf_waddr}, 32'd0);
        check("clr.wdata",    bus.rf_wdata,          32'd0);
        check("clr.md_ready", {31'd0, bus.md_ready}, 32'd1);
        check("clr.mw_ready", {31'd0, bus.mw_ready}, 32'd1);
        tick();
        @(negedge clk);
        clr = 1'b0;
        tick();
        check("clr.post1.we", {31'd0, bus.rf_we}, 32'd0);
        tick();
        check("clr.post2.we", {31'd0, bus.rf_we}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: clr  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: mw_valid  in  1  MEM/WB fields valid this cycle.
REQ-004 SHALL have ports: mw_ir  in  32  instruction; mw_o  in  32  ALU/PC+1 result; mw_d  in  32  load data.
REQ-005 SHALL have ports: mw_ready  out  1  pipeline entry accepted this cycle.
REQ-006 SHALL have ports: md_valid  in  1  mult/div done; md_rd  in  5  destination; md_result  in  32; md_is_div  in  1; md_exception  in  1.
REQ-007 SHALL have ports: md_ready  out  1  result buffer empty.
REQ-008 SHALL have ports: rf_we  out  1; rf_waddr  out  5; rf_wdata  out  32  registered register-file write port.

Function
REQ-009 SHALL decode opcode mw_ir[31:27]: 00000 (ALU) and 00101 (addi) -> rd=mw_ir[26:22], data=mw_o; 01000 (lw) -> rd=mw_ir[26:22], data=mw_d; 00011 (jal) -> rd=31, data=mw_o; 10101 (setx) -> rd=30, data=zero-extended mw_ir[26:0]; all other opcodes -> no write.
REQ-010 SHALL suppress any write whose destination is register 0 (rf_we stays 0; entry still consumed).
REQ-011 SHALL hold a one-entry multdiv buffer with states EMPTY and FULL; md_ready = (state == EMPTY).
REQ-012 SHALL capture md_rd/md_result/md_is_div/md_exception into the buffer when md_valid && md_ready; EMPTY -> FULL.
REQ-013 SHALL, when FULL, drive the write port from the buffer next edge and return to EMPTY; mw_ready = 0 that cycle.
REQ-014 SHALL, for a buffered exception, write rd=30 with data 32'd4 (mult) or 32'd5 (div), ignoring md_rd/md_result.
REQ-015 SHALL set mw_ready = 1 whenever state is EMPTY; a pipeline entry is accepted on mw_valid && mw_ready.
REQ-016 SHALL have write latency of exactly one cycle: accepted entry appears on rf_* at the following edge; rf_we = 0 in any cycle with nothing accepted or drained.
REQ-017 SHALL, on md_valid arriving in the same cycle state is EMPTY with mw_valid high, accept both: pipeline entry writes next edge, multdiv result enters buffer (drains the edge after).
REQ-018 SHALL ignore md_valid while FULL (md_ready=0; producer holds).
REQ-019 SHALL never issue two writes in one cycle; at most one of pipeline or buffer drives rf_* per edge.

Reset
REQ-020 SHALL, on clr high, asynchronously set state=EMPTY, buffer contents=0, rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-021 SHALL discard any buffered multdiv result and any in-flight write on reset mid-operation; no write issues in the first edge after clr falls.
REQ-022 SHALL drive mw_ready=1 and md_ready=1 during and immediately after reset.

Structure
REQ-023 SHALL take opcode constants (ALU, addi, lw, sw, jal, setx), register indices 30/31 and status codes 4/5 from the shared processor package.
REQ-024 SHALL place decode in one combinational sub-module wb_decode (in: ir; out: we, waddr, data-select), with arbitration and registers in wb_arbiter.

Verification
REQ-025 SHALL cover: reset, mw_valid=1, ir=addi rd=5, o=0x1234 -> next edge rf_we=1, waddr=5, wdata=0x00001234.
REQ-026 SHALL cover: lw rd=7, d=0xDEADBEEF, o=0x10 -> wdata=0xDEADBEEF, waddr=7; sw and bne -> rf_we=0.
REQ-027 SHALL cover: jal -> waddr=31, wdata=mw_o; setx target 0x0000123 -> waddr=30, wdata=0x00000123; addi rd=0 -> rf_we=0.
REQ-028 SHALL cover: md_valid rd=9 result=42 with mw_valid addi rd=3 same cycle -> edge1 write r3, edge2 write r9=42 with mw_ready=0 in between.
REQ-029 SHALL cover: md_valid md_exception=1 md_is_div=1 -> r30=5; md_is_div=0 -> r30=4; md_valid held while FULL is not double-captured.
REQ-030 SHALL cover: clr asserted while FULL -> buffer dropped, rf_we=0, md_ready=1 immediately.
